// File: rtl/mcc_sub_pipe.sv
// Pipelined Manchester-carry subtractor: diff = a - b - bin, one SLICE-bit borrow slice per stage.
// Optional MCC_SUB_FLAGS_EN adds registered zero / signed-overflow flags.

module mcc_sub_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] d,
    output logic         cout
);
    // Subtraction as a + ~b + cin; the carry ripples as a propagate/generate chain.
    always_comb begin
        logic c, p, g;
        c = cin;
        p = 1'b0;
        g = 1'b0;
        d = '0;
        for (int i = 0; i < W; i++) begin
            p    = a[i] ^ ~b[i];
            g    = a[i] & ~b[i];
            d[i] = p ^ c;
            c    = g | (p & c);
        end
        cout = c;
    end
endmodule

module mcc_sub_pipe #(
    parameter int SIZE  = 16,
    parameter int SLICE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            bin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] diff,
`ifdef MCC_SUB_FLAGS_EN
    output logic            zero,
    output logic            ovf,
`endif
    output logic            bout
);
    localparam int STAGES = SIZE / SLICE;

    logic                adv;
    logic [STAGES:0]     vld_pipe_q, vld_pipe_d;
    logic [SIZE-1:0]     diff_q, diff_d;
    logic                bout_q, bout_d;

    assign adv      = ~vld_pipe_q[STAGES] | out_ready;
    assign in_ready = adv;

    // Level k: a_q holds operand-a slices k.. in its low bits with finished diff
    // slices shifted in from the top; b_q holds only the b slices still to be consumed.
    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int BW = (STAGES - k) * SLICE;

        logic [SIZE-1:0]  a_q, a_d;
        logic [BW-1:0]    b_q, b_d;
        logic             cy_q, cy_d;
        logic [SLICE-1:0] sd;
        logic             sc;
        logic [SIZE-1:0]  nxt;

        mcc_sub_slice #(.W(SLICE)) u_slice (
            .a    (a_q[SLICE-1:0]),
            .b    (b_q[SLICE-1:0]),
            .cin  (cy_q),
            .d    (sd),
            .cout (sc)
        );

        assign nxt = (a_q >> SLICE) | (SIZE'(sd) << (SIZE - SLICE));

        if (k == 0) begin : g_head
            always_comb begin
                a_d  = a_q;
                b_d  = b_q;
                cy_d = cy_q;
                if (adv) begin
                    a_d  = a;
                    b_d  = b;
                    cy_d = ~bin;
                end
            end
        end else begin : g_body
            always_comb begin
                a_d  = a_q;
                b_d  = b_q;
                cy_d = cy_q;
                if (adv) begin
                    a_d  = g_stg[k-1].nxt;
                    b_d  = g_stg[k-1].b_q[BW+SLICE-1:SLICE];
                    cy_d = g_stg[k-1].sc;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                a_q  <= '0;
                b_q  <= '0;
                cy_q <= 1'b0;
            end else begin
                a_q  <= a_d;
                b_q  <= b_d;
                cy_q <= cy_d;
            end
        end
    end

`ifdef MCC_SUB_FLAGS_EN
    logic zero_q, zero_d;
    logic ovf_q, ovf_d;
`endif

    // Output regs load only on a valid final-stage beat so bubbles never disturb diff.
    always_comb begin
        vld_pipe_d = vld_pipe_q;
        diff_d     = diff_q;
        bout_d     = bout_q;
`ifdef MCC_SUB_FLAGS_EN
        zero_d     = zero_q;
        ovf_d      = ovf_q;
`endif
        if (adv) begin
            vld_pipe_d = {vld_pipe_q[STAGES-1:0], in_valid};
            if (vld_pipe_q[STAGES-1]) begin
                diff_d = g_stg[STAGES-1].nxt;
                bout_d = ~g_stg[STAGES-1].sc;
`ifdef MCC_SUB_FLAGS_EN
                zero_d = (g_stg[STAGES-1].nxt == '0);
                ovf_d  = (g_stg[STAGES-1].a_q[SLICE-1] != g_stg[STAGES-1].b_q[SLICE-1]) &
                         (g_stg[STAGES-1].nxt[SIZE-1] != g_stg[STAGES-1].a_q[SLICE-1]);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            diff_q     <= '0;
            bout_q     <= 1'b0;
`ifdef MCC_SUB_FLAGS_EN
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
`endif
        end else begin
            vld_pipe_q <= vld_pipe_d;
            diff_q     <= diff_d;
            bout_q     <= bout_d;
`ifdef MCC_SUB_FLAGS_EN
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign out_valid = vld_pipe_q[STAGES];
    assign diff      = diff_q;
    assign bout      = bout_q;
`ifdef MCC_SUB_FLAGS_EN
    assign zero      = zero_q;
    assign ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_mcc_sub_pipe.sv
// Scoreboard bench for mcc_sub_pipe: randomized and directed beats against an arithmetic model.
module tb_mcc_sub_pipe;
    localparam int SIZE  = 16;
    localparam int SLICE = 4;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, bin, out_valid, out_ready, bout;
    logic [SIZE-1:0] a, b, diff;
`ifdef MCC_SUB_FLAGS_EN
    logic zero, ovf;
`endif

    always #5 clk = ~clk;

    mcc_sub_pipe #(.SIZE(SIZE), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
`ifdef MCC_SUB_FLAGS_EN
        .zero      (zero),
        .ovf       (ovf),
`endif
        .bout      (bout)
    );

    typedef struct packed {
        logic [15:0] d;
        logic        bo;
        logic        z;
        logic        v;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic bi);
        exp_t e;
        int   full;
        full = int'(x) - int'(y) - int'(bi);
        e.d  = full[15:0];
        e.bo = (full < 0);
        e.z  = (e.d == 16'h0);
        e.v  = (x[15] != y[15]) && (e.d[15] != x[15]);
        return e;
    endfunction

    // Monitor: every negedge, compare a presented result with the oldest outstanding beat.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got diff %0h with no beat outstanding", diff);
                end else begin
                    mon_e = q[0];
                    chk("diff", {16'b0, diff}, {16'b0, mon_e.d});
                    chk("bout", {31'b0, bout}, {31'b0, mon_e.bo});
`ifdef MCC_SUB_FLAGS_EN
                    chk("zero", {31'b0, zero}, {31'b0, mon_e.z});
                    chk("ovf", {31'b0, ovf}, {31'b0, mon_e.v});
`endif
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, bin));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic bi, input logic r);
        in_valid  = v;
        a         = x;
        b         = y;
        bin       = bi;
        out_ready = r;
    endtask

    // One beat into an empty pipe: checks latency and the directed result.
    task automatic single(input string nm, input logic [15:0] x, input logic [15:0] y,
                          input logic bi, input logic [15:0] ed, input logic eb);
        int n;
        drive(1'b1, x, y, bi, 1'b1);
        cyc();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            cyc();
            n++;
        end
        chk({nm, "_latency"}, n, 4);
        chk({nm, "_diff"}, {16'b0, diff}, {16'b0, ed});
        chk({nm, "_bout"}, {31'b0, bout}, {31'b0, eb});
        cyc();
    endtask

    initial begin
        int first, last, cnt;
        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        cyc();
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_diff", {16'b0, diff}, 32'd0);
        chk("rst_bout", {31'b0, bout}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef MCC_SUB_FLAGS_EN
        chk("rst_zero", {31'b0, zero}, 32'd0);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
`endif
        cyc();

        single("basic", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0);
        single("wrap", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1);
`ifdef MCC_SUB_FLAGS_EN
        single("ovf", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0);
        chk("ovf_flag", {31'b0, ovf}, 32'd1);
        chk("ovf_zero", {31'b0, zero}, 32'd0);
`endif

        // Eight back-to-back beats must come out as one unbroken run.
        first = -1;
        last  = -1;
        cnt   = 0;
        for (int i = 0; i < 20; i++) begin
            if (i < 8) drive(1'b1, 16'(i * 16'h1111), 16'(i), i[0], 1'b1);
            else       in_valid = 1'b0;
            cyc();
            if (out_valid) begin
                if (first < 0) first = i;
                last = i;
                cnt++;
            end
        end
        chk("stream_count", cnt, 8);
        chk("stream_span", last - first + 1, 8);
        chk("stream_drained", q.size(), 0);

        // Stall with results waiting, then drain.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
            cyc();
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (5) cyc();
        chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        repeat (8) cyc();
        chk("stall_drained", q.size(), 0);

        // Reset with three beats in flight; in_valid during reset must be ignored.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'(16'h5000 + i), 16'(i), 1'b0, 1'b1);
            cyc();
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (out_valid) cnt++;
        end
        chk("midrst_no_ghost", cnt, 0);
        single("post_rst", 16'hABCD, 16'h0BCD, 1'b1, 16'h9FFF, 1'b0);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            drive(1'(($urandom % 4) != 0), 16'($urandom), 16'($urandom), 1'($urandom),
                  1'(($urandom % 4) != 0));
            if ((i % 50) == 7) begin
                a = 16'h0000;
                b = 16'hFFFF;
            end
            cyc();
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        repeat (10) cyc();
        chk("final_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
